action_arbiter: RTL and testbench

ACTION_ARBITER -- requirements
Module: action_arbiter

---
 rtl/mascota_pkg.sv | 26 ++
 rtl/action_arbiter_rise_detect.sv | 19 +
 rtl/action_arbiter.sv | 111 +++++++++++
 tb/tb_action_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mascota_pkg.sv
// Shared types for the pet controller: arbiter FSM states, action codes
// and the cooldown-length helper.
package mascota_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_COOL = 2'd3
    } state_t;

    // Codes double as one-hot pend masks: bit0 comida, bit1 medicina.
    localparam logic [1:0] ACT_NONE     = 2'b00;
    localparam logic [1:0] ACT_COMIDA   = 2'b01;
    localparam logic [1:0] ACT_MEDICINA = 2'b10;

    function automatic int unsigned cool_len(input int unsigned cycles,
                                             input int unsigned div,
                                             input logic        test);
        int unsigned q;
        if (!test || div == 0) return cycles;
        q = cycles / div;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/action_arbiter_rise_detect.sv
// One-bit rising-edge detector on a debounced level, registered previous value.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    // NOTE: prev resets to 1 so a button held through reset release gives no edge.
    always_ff @(posedge clk) begin
        if (!reset) prev <= 1'b1;
        else        prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/action_arbiter.sv
// Arbitrates food/medicine button presses into one action at a time, with
// handshake, completion timeout and a cooldown (shortened in test mode).
module action_arbiter
    import mascota_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYCLES = 50000000,
    parameter int unsigned TEST_DIV        = 10,
    parameter int unsigned TIMEOUT_CYCLES  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       test_db,
    input  logic       comida_db,
    input  logic       medicina_db,
    input  logic       act_ready,
    input  logic       act_done,
    output logic       act_valid,
    output logic [1:0] act_code,
    output logic       test_mode,
    output logic       busy,
    output logic [1:0] pend,
    output logic       err
);

    localparam int unsigned MAX_CYCLES =
        (COOLDOWN_CYCLES > TIMEOUT_CYCLES) ? COOLDOWN_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last_grant;
    logic [1:0]       next_grant;
    logic [1:0]       pend_set;
    logic [1:0]       pend_clr;
    logic             test_rise;
    logic             comida_rise;
    logic             medicina_rise;

    rise_detect u_test_rise     (.clk(clk), .reset(reset), .din(test_db),     .rise(test_rise));
    rise_detect u_comida_rise   (.clk(clk), .reset(reset), .din(comida_db),   .rise(comida_rise));
    rise_detect u_medicina_rise (.clk(clk), .reset(reset), .din(medicina_db), .rise(medicina_rise));

    assign pend_set = {medicina_rise, comida_rise};
    assign busy     = (state != S_IDLE);

    always_comb begin
        pend_clr = 2'b00;
        if (state == S_REQ && act_ready) pend_clr = act_code;

        next_grant = ACT_MEDICINA;
        if (pend == 2'b11)
            next_grant = (last_grant == ACT_COMIDA) ? ACT_MEDICINA : ACT_COMIDA;
        else if (pend[0])
            next_grant = ACT_COMIDA;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            act_valid  <= 1'b0;
            act_code   <= ACT_NONE;
            test_mode  <= 1'b0;
            pend       <= 2'b00;
            err        <= 1'b0;
            cnt        <= '0;
            last_grant <= ACT_MEDICINA;
        end else begin
            // A new press landing on its own clear keeps the flag set.
            pend <= (pend & ~pend_clr) | pend_set;
            if (test_rise) test_mode <= ~test_mode;

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        state      <= S_REQ;
                        act_valid  <= 1'b1;
                        act_code   <= next_grant;
                        last_grant <= next_grant;
                    end
                end
                S_REQ: begin
                    if (act_ready) begin
                        state     <= S_WAIT;
                        act_valid <= 1'b0;
                        act_code  <= ACT_NONE;
                        cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    if (act_done || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (!act_done) err <= 1'b1;
                        state <= S_COOL;
                        cnt   <= CNT_W'(cool_len(COOLDOWN_CYCLES, TEST_DIV, test_mode));
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_COOL: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_action_arbiter.sv
// Directed-vector bench for action_arbiter with short cooldown/timeout values.
module tb_action_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       test_db;
    logic       comida_db;
    logic       medicina_db;
    logic       act_ready;
    logic       act_done;
    logic       act_valid;
    logic [1:0] act_code;
    logic       test_mode;
    logic       busy;
    logic [1:0] pend;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    action_arbiter #(
        .COOLDOWN_CYCLES(8),
        .TEST_DIV       (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .test_db    (test_db),
        .comida_db  (comida_db),
        .medicina_db(medicina_db),
        .act_ready  (act_ready),
        .act_done   (act_done),
        .act_valid  (act_valid),
        .act_code   (act_code),
        .test_mode  (test_mode),
        .busy       (busy),
        .pend       (pend),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(act_valid), 32'd0);
        check({tag, "_code"},  32'(act_code),  32'd0);
        check({tag, "_tmode"}, 32'(test_mode), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_pend"},  32'(pend),      32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
    endtask

    // Counts sampled cycles with busy high, starting from the current sample.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic pulse_done();
        act_done = 1'b1;
        step();
        act_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        reset       = 1'b0;
        test_db     = 1'b0;
        comida_db   = 1'b0;
        medicina_db = 1'b0;
        act_ready   = 1'b0;
        act_done    = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b1;
        step();
        step();

        // Single comida request, 3-cycle action, 8-cycle cooldown.
        comida_db = 1'b1;
        act_ready = 1'b1;
        step();
        check("a_pend", 32'(pend), 32'd1);
        check("a_idle_valid", 32'(act_valid), 32'd0);
        step();
        check("a_valid", 32'(act_valid), 32'd1);
        check("a_code", 32'(act_code), 32'd1);
        check("a_busy", 32'(busy), 32'd1);
        comida_db = 1'b0;
        step();
        check("a_wait_valid", 32'(act_valid), 32'd0);
        check("a_wait_code", 32'(act_code), 32'd0);
        check("a_wait_pend", 32'(pend), 32'd0);
        step();
        step();
        check("a_wait_busy", 32'(busy), 32'd1);
        pulse_done();
        measure_busy(n);
        check("a_cool_len", 32'(n), 32'd8);
        check("a_no_err", 32'(err), 32'd0);

        // Simultaneous comida and medicina: round-robin starts with comida.
        do_reset();
        act_ready   = 1'b0;
        comida_db   = 1'b1;
        medicina_db = 1'b1;
        step();
        check("b_pend_both", 32'(pend), 32'd3);
        step();
        check("b_first_valid", 32'(act_valid), 32'd1);
        check("b_first_code", 32'(act_code), 32'd1);
        act_ready = 1'b1;
        step();
        check("b_pend_after1", 32'(pend), 32'd2);
        pulse_done();
        measure_busy(n);
        check("b_cool1", 32'(n), 32'd8);
        step();
        check("b_second_valid", 32'(act_valid), 32'd1);
        check("b_second_code", 32'(act_code), 32'd2);
        step();
        check("b_pend_after2", 32'(pend), 32'd0);
        comida_db   = 1'b0;
        medicina_db = 1'b0;
        pulse_done();
        measure_busy(n);
        check("b_cool2", 32'(n), 32'd8);

        // Test mode shortens cooldown; a toggle mid-cooldown does not change it.
        test_db = 1'b1;
        step();
        check("c_tmode_on", 32'(test_mode), 32'd1);
        test_db   = 1'b0;
        comida_db = 1'b1;
        step();
        step();
        check("c_code", 32'(act_code), 32'd1);
        step();
        comida_db = 1'b0;
        pulse_done();
        measure_busy(n);
        check("c_cool_test", 32'(n), 32'd2);
        comida_db = 1'b1;
        step();
        step();
        step();
        comida_db = 1'b0;
        pulse_done();
        test_db = 1'b1;
        measure_busy(n);
        test_db = 1'b0;
        check("c_cool_toggled", 32'(n), 32'd2);
        check("c_tmode_off", 32'(test_mode), 32'd0);

        // Stall in REQ for 5 cycles, then time out in WAIT.
        act_ready   = 1'b0;
        medicina_db = 1'b1;
        step();
        check("d_pend", 32'(pend), 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("d_hold_valid%0d", i), 32'(act_valid), 32'd1);
            check($sformatf("d_hold_code%0d", i), 32'(act_code), 32'd2);
            step();
        end
        act_ready = 1'b1;
        step();
        act_ready   = 1'b0;
        medicina_db = 1'b0;
        check("d_wait_err0", 32'(err), 32'd0);
        n = 0;
        while (!err && n < 100) begin
            step();
            n++;
        end
        check("d_timeout_len", 32'(n), 32'd16);
        check("d_err_busy", 32'(busy), 32'd1);
        measure_busy(n);
        check("d_cool_len", 32'(n), 32'd8);
        check("d_err_sticky", 32'(err), 32'd1);

        // Reset during WAIT with medicina held: no grant after release.
        act_ready   = 1'b1;
        medicina_db = 1'b1;
        step();
        step();
        step();
        check("e_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        step();
        check_reset_outputs("e_rst");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("e_valid%0d", i), 32'(act_valid), 32'd0);
            check($sformatf("e_pend%0d", i), 32'(pend), 32'd0);
            check($sformatf("e_busy%0d", i), 32'(busy), 32'd0);
        end
        medicina_db = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
